// File: rtl/mul_hilo_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: funct codes, FSM states, widths.
// Consumers: hilo_reg, mul_hilo_ctrl (optional feature macro MUL_ZERO_SKIP_EN lives in the top).
package mul_hilo_pkg;

  localparam int DATA_W  = 32;
  localparam int DDATA_W = 64;
  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_RUN  = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_st_e;

  function automatic logic is_mul_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO architectural register pair: one 64-bit write port {HI,LO} with
// independent half enables, synchronous active-high reset.
module hilo_reg
  import mul_hilo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_hi_we,
  input  logic               i_lo_we,
  input  logic [DDATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0]  o_hi,
  output logic [DATA_W-1:0]  o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    // NOTE: HI/LO are architectural state visible to MFHI/MFLO, so they take
    // the reset like the FSM does; a plain data buffer would not need it.
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_wdata[DDATA_W-1:DATA_W];
      if (i_lo_we) r_lo <= i_wdata[DATA_W-1:0];
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage multiply sequencer and HI/LO owner: issues MULT/MULTU, stalls until the
// product is captured, services MTHI/MTLO/MFHI/MFLO. Optional macro: MUL_ZERO_SKIP_EN.
module mul_hilo_ctrl
  import mul_hilo_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_en,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        stall_i,
  input  logic        flush,
  output logic        mul_en,
  output logic [5:0]  mul_funct,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic        mul_done,
  input  logic [63:0] mul_result,
  output logic        stall_req,
  output logic [31:0] hilo_rdata,
  output logic        busy
);

  if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_latency
    $error("mul_hilo_ctrl: MUL_LATENCY must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  mul_st_e     r_state;
  logic [3:0]  r_cnt;
  logic        r_mul_en;
  logic [5:0]  r_mul_funct;
  logic [31:0] r_mul_op1;
  logic [31:0] r_mul_op2;

  logic        w_cmd_ok;
  logic        w_is_mul;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_zero_skip;
  logic        w_issue;
  logic        w_skip_wr;
  logic        w_finish;
  logic        w_capture;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [63:0] w_wdata;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  // Only IDLE accepts new HI/LO-class work; flush kills it before any side effect.
  assign w_cmd_ok  = (r_state == MUL_ST_IDLE) && ex_en && !flush;
  assign w_is_mul  = is_mul_funct(funct);
  assign w_is_mthi = (funct == FUNCT_MTHI);
  assign w_is_mtlo = (funct == FUNCT_MTLO);

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero_skip = (operand_1 == '0) || (operand_2 == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  assign w_issue   = w_cmd_ok && w_is_mul && !w_zero_skip;
  assign w_skip_wr = w_cmd_ok && w_is_mul && w_zero_skip;
  assign w_finish  = (r_state == MUL_ST_RUN) && (r_cnt == 4'd0) && mul_done;
  assign w_capture = w_finish && !flush;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    w_hi_we = 1'b0;
    w_lo_we = 1'b0;
    w_wdata = {operand_1, operand_1};
    if (w_capture) begin
      w_hi_we = 1'b1;
      w_lo_we = 1'b1;
      w_wdata = mul_result;
    end else if (w_skip_wr) begin
      w_hi_we = 1'b1;
      w_lo_we = 1'b1;
      w_wdata = '0;
    end else if (w_cmd_ok) begin
      w_hi_we = w_is_mthi;
      w_lo_we = w_is_mtlo;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= MUL_ST_IDLE;
      r_cnt       <= 4'd0;
      r_mul_en    <= 1'b0;
      r_mul_funct <= '0;
      r_mul_op1   <= '0;
      r_mul_op2   <= '0;
    end else begin
      case (r_state)
        MUL_ST_IDLE: begin
          if (w_issue) begin
            r_state     <= MUL_ST_RUN;
            r_cnt       <= CNT_INIT;
            r_mul_en    <= 1'b1;
            r_mul_funct <= funct;
            r_mul_op1   <= operand_1;
            r_mul_op2   <= operand_2;
          end
        end
        MUL_ST_RUN: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          if (flush) begin
            r_state  <= MUL_ST_IDLE;
            r_mul_en <= 1'b0;
          end else if (w_finish) begin
            // DONE parks the FSM so the still-held MULT is not issued twice.
            r_state  <= stall_i ? MUL_ST_DONE : MUL_ST_IDLE;
            r_mul_en <= 1'b0;
          end
        end
        MUL_ST_DONE: begin
          if (flush || !stall_i) r_state <= MUL_ST_IDLE;
        end
        default: begin
          r_state  <= MUL_ST_IDLE;
          r_mul_en <= 1'b0;
        end
      endcase
    end
  end

  hilo_reg u_hilo_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hi_we (w_hi_we),
    .i_lo_we (w_lo_we),
    .i_wdata (w_wdata),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  always_comb begin
    hilo_rdata = '0;
    if (funct == FUNCT_MFHI)      hilo_rdata = w_hi;
    else if (funct == FUNCT_MFLO) hilo_rdata = w_lo;
  end

  // The issue cycle stalls combinationally; RUN stalls until the capture cycle.
  assign stall_req = w_issue || ((r_state == MUL_ST_RUN) && !w_finish);
  assign busy      = (r_state != MUL_ST_IDLE);
  assign mul_en    = r_mul_en;
  assign mul_funct = r_mul_funct;
  assign mul_op1   = r_mul_op1;
  assign mul_op2   = r_mul_op2;

endmodule
